uart_rx_cfg: RTL and testbench

- Configurable UART receiver, the parametrised successor of the fixed 8N1 receiver in the DAC control path.
- Supports 5–9 data bits, none/odd/even parity, and 1 or 2 stop bits.
- Samples each bit with a 3-sample majority vote and detects parity errors, framing errors and line breaks.
- Presents received words on a valid/ready interface with a one-word holding register and overrun reporting; feeds the command parser.

---
 rtl/uart_rx_cfg.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits,
// 3-sample majority voting, break detection and a one-word valid/ready holding register.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 rx_busy
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF     = BAUD_DIV / 2;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic HAS_PAR  = (PARITY != 0);
  localparam logic ODD_MODE = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != ODD_MODE;
  endfunction

  state_t               state_q, state_d;
  logic                 s1_q, s1_d, s2_q, s2_d;
  logic [2:0]           sh_q, sh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d, pe_q, pe_d;
  logic                 stop0_q, stop0_d, fe_q, fe_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 break_q, break_d, busy_q, busy_d;
  logic                 maj, stop0_now, fe_now;

  assign maj = maj3(sh_q);

  // Next-state and output computation for the receive FSM and holding register.
  always_comb begin
    s1_d = rx_pin;
    s2_d = s1_q;
    sh_d = {sh_q[1:0], s2_q};
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_bit_d = par_bit_q;
    pe_d = pe_q;
    stop0_d = stop0_q;
    fe_d = fe_q;
    stop0_now = stop0_q;
    fe_now = fe_q;
    rx_data_d = rx_data_q;
    rx_valid_d = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d = frame_err_q;
    overrun_d = 1'b0;
    break_d = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (s2_q && !s1_q) begin
          state_d = S_START;
          cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = {CNT_W{1'b0}};
          if (!maj) begin
            state_d = S_DATA;
            bit_d = 4'd0;
            par_bit_d = 1'b0;
            pe_d = 1'b0;
            stop0_d = 1'b1;
            fe_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = {CNT_W{1'b0}};
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d = 4'd0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = {CNT_W{1'b0}};
          par_bit_d = maj;
          pe_d = parity_bad(shift_q, maj);
          bit_d = 4'd0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = {CNT_W{1'b0}};
          stop0_now = (bit_q == 4'd0) ? maj : stop0_q;
          fe_now = fe_q | ~maj;
          stop0_d = stop0_now;
          fe_d = fe_now;
          if (bit_q == LAST_STOP) begin
            bit_d = 4'd0;
            // A break (all-zero frame) is reported but never delivered or counted as overrun.
            if ((shift_q == {DATA_BITS{1'b0}}) && !par_bit_q && !stop0_now) begin
              break_d = 1'b1;
              state_d = S_WAIT_IDLE;
            end else begin
              if (!rx_valid_q || rx_ready) begin
                rx_data_d = shift_q;
                rx_valid_d = 1'b1;
                parity_err_d = pe_q;
                frame_err_d = fe_now;
              end else begin
                overrun_d = 1'b1;
              end
              state_d = fe_now ? S_WAIT_IDLE : S_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (s2_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      sh_q <= 3'b111;
      cnt_q <= {CNT_W{1'b0}};
      bit_q <= 4'd0;
      shift_q <= {DATA_BITS{1'b0}};
      par_bit_q <= 1'b0;
      pe_q <= 1'b0;
      stop0_q <= 1'b1;
      fe_q <= 1'b0;
      rx_data_q <= {DATA_BITS{1'b0}};
      rx_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
      break_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_bit_q <= par_bit_d;
      pe_q <= pe_d;
      stop0_q <= stop0_d;
      fe_q <= fe_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
      break_q <= break_d;
      busy_q <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E2 instance, each checked every cycle against a
// frame-level model (expected word/flags/completion cycle per frame) plus literal pins.
module tb_uart_rx_cfg;

  localparam int CF = 1_600_000;
  localparam int BR = 100_000;
  localparam int BD = 16;
  localparam int ND    [2] = '{8, 7};
  localparam int NPAR  [2] = '{0, 2};
  localparam int NSTOP [2] = '{1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rx_pin   [2] = '{1'b1, 1'b1};
  logic rx_ready [2] = '{1'b0, 1'b0};
  bit   rdy_man  [2] = '{1'b0, 1'b0};
  bit   rdy_rand [2] = '{1'b0, 1'b0};

  logic [7:0] rx_data0;
  logic [6:0] rx_data1;
  logic rx_valid0, rx_valid1, parity_err0, parity_err1, frame_err0, frame_err1;
  logic overrun0, overrun1, break_det0, break_det1, rx_busy0, rx_busy1;

  uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin[0]), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready[0]), .parity_err(parity_err0), .frame_err(frame_err0), .overrun(overrun0),
    .break_det(break_det0), .rx_busy(rx_busy0));

  uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin[1]), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready[1]), .parity_err(parity_err1), .frame_err(frame_err1), .overrun(overrun1),
    .break_det(break_det1), .rx_busy(rx_busy1));

  logic [8:0] dd [2];
  logic dv [2], dpe [2], dfe [2], dov [2], dbrk [2], dbusy [2];
  always_comb begin
    dd[0] = {1'b0, rx_data0};   dd[1] = {2'b00, rx_data1};
    dv[0] = rx_valid0;          dv[1] = rx_valid1;
    dpe[0] = parity_err0;       dpe[1] = parity_err1;
    dfe[0] = frame_err0;        dfe[1] = frame_err1;
    dov[0] = overrun0;          dov[1] = overrun1;
    dbrk[0] = break_det0;       dbrk[1] = break_det1;
    dbusy[0] = rx_busy0;        dbusy[1] = rx_busy1;
  end

  typedef struct {
    int         inst;
    int         comp;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } ev_t;
  ev_t evq[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic       m_valid [2] = '{1'b0, 1'b0};
  logic [8:0] m_data  [2] = '{9'd0, 9'd0};
  logic       m_pe [2] = '{1'b0, 1'b0};
  logic       m_fe [2] = '{1'b0, 1'b0};
  logic       m_ov [2] = '{1'b0, 1'b0};
  logic       m_brk [2] = '{1'b0, 1'b0};
  int rise [2] = '{0, 0};
  int ov_cnt [2] = '{0, 0};
  int brk_cnt [2] = '{0, 0};
  logic prev_v [2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: the holding register reacts only to frame completions and handshakes.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        logic vb;
        vb = m_valid[i];
        m_ov[i] = 1'b0;
        m_brk[i] = 1'b0;
        if (rst_n && vb && rx_ready[i]) begin
          m_valid[i] = 1'b0;
          m_pe[i] = 1'b0;
          m_fe[i] = 1'b0;
        end
        for (int k = evq.size() - 1; k >= 0; k--) begin
          if (evq[k].inst == i && evq[k].comp == cyc) begin
            if (evq[k].brk) m_brk[i] = 1'b1;
            else if (!vb || rx_ready[i]) begin
              m_valid[i] = 1'b1;
              m_data[i] = evq[k].data;
              m_pe[i] = evq[k].pe;
              m_fe[i] = evq[k].fe;
            end else m_ov[i] = 1'b1;
            evq.delete(k);
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("rx_valid%0d", i), 32'(dv[i]), 32'(m_valid[i]));
          check($sformatf("rx_data%0d", i), 32'(dd[i]), 32'(m_data[i]));
          check($sformatf("parity_err%0d", i), 32'(dpe[i]), 32'(m_pe[i]));
          check($sformatf("frame_err%0d", i), 32'(dfe[i]), 32'(m_fe[i]));
          check($sformatf("overrun%0d", i), 32'(dov[i]), 32'(m_ov[i]));
          check($sformatf("break_det%0d", i), 32'(dbrk[i]), 32'(m_brk[i]));
          if (dv[i] && !prev_v[i]) rise[i] = cyc;
          prev_v[i] = dv[i];
          if (dov[i]) ov_cnt[i]++;
          if (dbrk[i]) brk_cnt[i]++;
        end
      end
    end
  end

  // Consumer: either a fixed level from the main sequence or random back-pressure.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        rx_ready[i] = rdy_rand[i] ? ($urandom_range(0, 3) != 0) : rdy_man[i];
    end
  end

  // Drive one frame cell-by-cell and enqueue its expected outcome; call #1 after a posedge.
  task automatic send(input int i, input logic [8:0] d, input logic pb, input logic [1:0] st,
                      input int hold, input int spike, input int gap, input bit pulse, output int c0);
    logic lv[$];
    ev_t ev;
    logic [8:0] dm;
    int n, ones;
    c0 = cyc;
    dm = d & ((9'd1 << ND[i]) - 9'd1);
    repeat (BD) lv.push_back(1'b0);
    for (int b = 0; b < ND[i]; b++) repeat (BD) lv.push_back(dm[b]);
    if (NPAR[i] != 0) repeat (BD) lv.push_back(pb);
    for (int s = 0; s < NSTOP[i]; s++) repeat (BD) lv.push_back(st[s]);
    repeat (hold) lv.push_back(1'b0);
    repeat (gap) lv.push_back(1'b1);
    if (spike >= 0) lv[spike] = ~lv[spike];
    n = ND[i] + ((NPAR[i] != 0) ? 1 : 0) + NSTOP[i];
    ones = $countones(dm) + ((NPAR[i] != 0) ? int'(pb) : 0);
    ev.inst = i;
    // 2 synchroniser cycles, HALF+1 cycles to the start decision, then one cell per bit.
    ev.comp = c0 + 2 + BD / 2 + 1 + BD * n;
    ev.data = dm;
    ev.pe = (NPAR[i] == 1) ? (ones % 2 == 0) : (NPAR[i] == 2) ? (ones % 2 == 1) : 1'b0;
    ev.fe = (st[0] == 1'b0) || (NSTOP[i] == 2 && st[1] == 1'b0);
    ev.brk = (dm == 9'd0) && (NPAR[i] == 0 || pb == 1'b0) && (st[0] == 1'b0);
    evq.push_back(ev);
    foreach (lv[k]) begin
      rx_pin[i] = lv[k];
      if (pulse) rdy_man[i] = (cyc == ev.comp - 1);
      tick(1);
    end
    if (pulse) rdy_man[i] = 1'b0;
  endtask

  task automatic rand_run(input int i, input int n);
    int c0, hold;
    logic [8:0] d;
    logic pb;
    logic [1:0] st;
    for (int k = 0; k < n; k++) begin
      d = 9'($urandom);
      if ($urandom_range(0, 7) == 0) d = 9'd0;
      pb = (NPAR[i] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      st[0] = ($urandom_range(0, 7) != 0);
      st[1] = ($urandom_range(0, 7) != 0);
      hold = (st[NSTOP[i] - 1] == 1'b0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      send(i, d, pb, st, hold, -1, $urandom_range(6, 30), 1'b0, c0);
    end
  endtask

  initial begin
    int c0, g, ov0, brk0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_valid0", 32'(rx_valid0), 32'd0);
    check("reset rx_data0", 32'(rx_data0), 32'd0);
    check("reset rx_busy0", 32'(rx_busy0), 32'd0);
    check("reset rx_busy1", 32'(rx_busy1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);

    // 8N1 0xA5 with consumer ready
    rdy_man[0] = 1'b1;
    send(0, 9'h0A5, 1'b0, 2'b11, 0, -1, 20, 1'b0, c0);
    check("a5 latency", 32'(rise[0] - c0), 32'd155);
    check("a5 data", 32'(rx_data0), 32'h0A5);
    check("a5 consumed", 32'(rx_valid0), 32'd0);

    // 7E2 0x41, correct then wrong parity bit
    send(1, 9'h041, 1'b0, 2'b11, 0, -1, 20, 1'b0, c0);
    check("7e2 latency", 32'(rise[1] - c0), 32'd171);
    check("41 data", 32'(rx_data1), 32'h41);
    check("41 pe ok", 32'(parity_err1), 32'd0);
    rdy_man[1] = 1'b1; tick(3); rdy_man[1] = 1'b0;
    send(1, 9'h041, 1'b1, 2'b11, 0, -1, 20, 1'b0, c0);
    check("41 pe bad", 32'(parity_err1), 32'd1);
    check("41 valid", 32'(rx_valid1), 32'd1);
    rdy_man[1] = 1'b1; tick(3); rdy_man[1] = 1'b0;

    // 3-cycle glitch is rejected
    g = cyc;
    rx_pin[0] = 1'b0; tick(3); rx_pin[0] = 1'b1;
    check("glitch busy", 32'(rx_busy0), 32'd1);
    tick(25);
    check("glitch idle", 32'(rx_busy0), 32'd0);
    check("glitch no word", 32'(rx_valid0), 32'd0);

    // single-cycle high spike in data bit 3 of 0x00
    send(0, 9'h000, 1'b0, 2'b11, 0, BD * 4 + 7, 20, 1'b0, c0);
    check("spike data", 32'(rx_data0), 32'h00);

    // stop bit low on 0x3C, line held low afterwards
    rdy_man[0] = 1'b0;
    send(0, 9'h03C, 1'b0, 2'b00, 40, -1, 20, 1'b0, c0);
    check("fe valid", 32'(rx_valid0), 32'd1);
    check("fe flag", 32'(frame_err0), 32'd1);
    check("fe data", 32'(rx_data0), 32'h3C);
    rdy_man[0] = 1'b1; tick(3);

    // 12 bit times low -> one break pulse, then 0x55
    brk0 = brk_cnt[0];
    send(0, 9'h000, 1'b0, 2'b00, 12 * BD - 10 * BD, -1, 20, 1'b0, c0);
    check("break count", 32'(brk_cnt[0] - brk0), 32'd1);
    check("break no word", 32'(rx_valid0), 32'd0);
    send(0, 9'h055, 1'b0, 2'b11, 0, -1, 20, 1'b0, c0);
    check("after break data", 32'(rx_data0), 32'h55);

    // overrun, then accept-and-load on the completion cycle
    rdy_man[0] = 1'b0;
    ov0 = ov_cnt[0];
    send(0, 9'h011, 1'b0, 2'b11, 0, -1, 10, 1'b0, c0);
    send(0, 9'h022, 1'b0, 2'b11, 0, -1, 10, 1'b0, c0);
    check("overrun held", 32'(rx_data0), 32'h11);
    check("overrun pulses", 32'(ov_cnt[0] - ov0), 32'd1);
    send(0, 9'h033, 1'b0, 2'b11, 0, -1, 10, 1'b1, c0);
    check("swap data", 32'(rx_data0), 32'h33);
    check("swap valid", 32'(rx_valid0), 32'd1);
    check("swap no overrun", 32'(ov_cnt[0] - ov0), 32'd1);
    rdy_man[0] = 1'b1; tick(3);

    // randomized frames on both receivers with random back-pressure
    rdy_rand[0] = 1'b1;
    rdy_rand[1] = 1'b1;
    fork
      rand_run(0, 40);
      rand_run(1, 40);
    join
    rdy_rand[0] = 1'b0; rdy_rand[1] = 1'b0;
    rdy_man[0] = 1'b1;  rdy_man[1] = 1'b1;
    tick(50);
    check("all frames completed", 32'(evq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
